// File: rtl/tap_pkg.sv
// ---------------------------------------------------------------------------
// tap_pkg
// Shared definitions for the IEEE 1149.1 TAP controller:
//   - TAP_STATE_W : width of the state code (4)
//   - tap_state_e : the 16 TAP states with the standard 1149.1 encoding
//   - tap_ctrl_t  : bundle of decoded control outputs
//   - tap_decode  : maps a state to its control outputs
// ---------------------------------------------------------------------------
package tap_pkg;

    localparam int TAP_STATE_W = 4;

    typedef enum logic [TAP_STATE_W-1:0] {
        EX2DR = 4'h0,
        EX1DR = 4'h1,
        SHDR  = 4'h2,
        PSDR  = 4'h3,
        SELIR = 4'h4,
        UPDR  = 4'h5,
        CAPDR = 4'h6,
        SELDR = 4'h7,
        EX2IR = 4'h8,
        EX1IR = 4'h9,
        SHIR  = 4'hA,
        PSIR  = 4'hB,
        RTI   = 4'hC,
        UPIR  = 4'hD,
        CAPIR = 4'hE,
        TLR   = 4'hF
    } tap_state_e;

    typedef struct packed {
        logic test_log_res;
        logic shift_ir;
        logic ir_sh_en;
        logic ir_com_en;
        logic shift_dr;
        logic dr_sh_en;
        logic dr_com_en;
        logic sel_ir;
        logic tdo_en;
    } tap_ctrl_t;

    // Control outputs as a pure function of the state. The top registers the
    // result for the upcoming state, so outputs line up with Tap_state.
    function automatic tap_ctrl_t tap_decode(input tap_state_e s);
        tap_ctrl_t c;
        c              = '0;
        c.test_log_res = (s == TLR);
        c.shift_ir     = (s == SHIR);
        c.ir_sh_en     = (s == CAPIR) || (s == SHIR);
        c.ir_com_en    = (s == UPIR);
        c.shift_dr     = (s == SHDR);
        c.dr_sh_en     = (s == CAPDR) || (s == SHDR);
        c.dr_com_en    = (s == UPDR);
        // TDO follows the IR chain in TLR and throughout the IR branch.
        c.sel_ir       = (s == TLR)  || (s == SELIR) || (s == CAPIR) ||
                         (s == SHIR) || (s == EX1IR) || (s == PSIR)  ||
                         (s == EX2IR) || (s == UPIR);
        c.tdo_en       = (s == SHIR) || (s == SHDR);
        return c;
    endfunction

endpackage

// File: rtl/tap_next_state.sv
// ---------------------------------------------------------------------------
// tap_next_state
// Combinational TAP state transition table.
//   state      in  tap_state_e  current TAP state
//   tms        in  1            test mode select
//   next_state out tap_state_e  state after the next rising TCK
// ---------------------------------------------------------------------------
module tap_next_state
    import tap_pkg::*;
(
    input  tap_state_e state,
    input  logic       tms,
    output tap_state_e next_state
);

    always_comb begin
        next_state = TLR;
        case (state)
            TLR:   next_state = tms ? TLR   : RTI;
            RTI:   next_state = tms ? SELDR : RTI;
            SELDR: next_state = tms ? SELIR : CAPDR;
            SELIR: next_state = tms ? TLR   : CAPIR;
            CAPDR: next_state = tms ? EX1DR : SHDR;
            SHDR:  next_state = tms ? EX1DR : SHDR;
            EX1DR: next_state = tms ? UPDR  : PSDR;
            PSDR:  next_state = tms ? EX2DR : PSDR;
            EX2DR: next_state = tms ? UPDR  : SHDR;
            UPDR:  next_state = tms ? SELDR : RTI;
            CAPIR: next_state = tms ? EX1IR : SHIR;
            SHIR:  next_state = tms ? EX1IR : SHIR;
            EX1IR: next_state = tms ? UPIR  : PSIR;
            PSIR:  next_state = tms ? EX2IR : PSIR;
            EX2IR: next_state = tms ? UPIR  : SHIR;
            UPIR:  next_state = tms ? SELDR : RTI;
            default: next_state = TLR;
        endcase
    end

endmodule

// File: rtl/tap_controller.sv
// ---------------------------------------------------------------------------
// tap_controller
// IEEE 1149.1 16-state TAP controller; sole source of IR/DR cell controls.
// Optional feature macro: TAP_RTI_CNT_EN (adds the Run-Test/Idle counter).
//   clk          in   TCK, all state changes on rising edge
//   reset        in   TRST, asynchronous, active-low
//   TMS          in   test mode select
//   Test_Log_Res out  1 in Test-Logic-Reset
//   Shift_IR     out  1 in Shift-IR
//   IR_Sh_t_en   out  IR shift-stage enable (Capture-IR, Shift-IR)
//   IR_Com_t_en  out  IR update-stage enable (Update-IR)
//   Shift_DR     out  1 in Shift-DR
//   DR_Sh_t_en   out  DR shift-stage enable (Capture-DR, Shift-DR)
//   DR_Com_t_en  out  DR update-stage enable (Update-DR)
//   Sel_IR       out  TDO source: 1 = IR chain, 0 = DR chain
//   TDO_en       out  TDO output enable
//   Tap_state    out  current 4-bit state code
//   Rti_cnt      out  Run-Test/Idle counter (TAP_RTI_CNT_EN only)
// ---------------------------------------------------------------------------
module tap_controller
    import tap_pkg::*;
#(
    parameter int RTI_CNT_W = 16
)
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   TMS,
    output logic                   Test_Log_Res,
    output logic                   Shift_IR,
    output logic                   IR_Sh_t_en,
    output logic                   IR_Com_t_en,
    output logic                   Shift_DR,
    output logic                   DR_Sh_t_en,
    output logic                   DR_Com_t_en,
    output logic                   Sel_IR,
    output logic                   TDO_en,
    output logic [TAP_STATE_W-1:0] Tap_state
`ifdef TAP_RTI_CNT_EN
    ,
    output logic [RTI_CNT_W-1:0]   Rti_cnt
`endif
);

    tap_state_e state;
    tap_state_e next_state;
    tap_ctrl_t  ctrl;

    tap_next_state u_next_state (
        .state      (state),
        .tms        (TMS),
        .next_state (next_state)
    );

    // Outputs are flops loaded from the decode of the next state, so they are
    // glitch-free and valid in the same cycle as the state they describe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= TLR;
            ctrl  <= tap_decode(TLR);
        end else begin
            state <= next_state;
            ctrl  <= tap_decode(next_state);
        end
    end

    assign Tap_state    = state;
    assign Test_Log_Res = ctrl.test_log_res;
    assign Shift_IR     = ctrl.shift_ir;
    assign IR_Sh_t_en   = ctrl.ir_sh_en;
    assign IR_Com_t_en  = ctrl.ir_com_en;
    assign Shift_DR     = ctrl.shift_dr;
    assign DR_Sh_t_en   = ctrl.dr_sh_en;
    assign DR_Com_t_en  = ctrl.dr_com_en;
    assign Sel_IR       = ctrl.sel_ir;
    assign TDO_en       = ctrl.tdo_en;

`ifdef TAP_RTI_CNT_EN
    // Counts edges spent in Run-Test/Idle, saturating; cleared when a capture
    // state is entered so each RUNBIST window starts from zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Rti_cnt <= '0;
        end else if ((next_state == CAPDR) || (next_state == CAPIR)) begin
            Rti_cnt <= '0;
        end else if ((state == RTI) && (Rti_cnt != '1)) begin
            Rti_cnt <= Rti_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_tap_controller.sv
// ---------------------------------------------------------------------------
// tb_tap_controller
// Self-checking bench for tap_controller. The reference model tracks the TAP
// as (phase, branch) and derives codes and controls from that view.
// Build with TAP_RTI_CNT_EN to also check the Run-Test/Idle counter.
// ---------------------------------------------------------------------------
module tb_tap_controller;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    // Phases of the TAP walk; the IR/DR branch is tracked separately.
    localparam int P_TLR = 0, P_RTI = 1, P_SEL = 2, P_CAP = 3, P_SH = 4,
                   P_EX1 = 5, P_PS = 6, P_EX2 = 7, P_UP = 8;

    logic       clk;
    logic       reset;
    logic       TMS;
    logic       Test_Log_Res, Shift_IR, IR_Sh_t_en, IR_Com_t_en;
    logic       Shift_DR, DR_Sh_t_en, DR_Com_t_en, Sel_IR, TDO_en;
    logic [3:0] Tap_state;
`ifdef TAP_RTI_CNT_EN
    logic [CNT_W-1:0] Rti_cnt;
`endif

    int vectors     = 0;
    int miscompares = 0;
    bit checkEn     = 0;

    int mPhase = P_TLR;
    bit mIr    = 0;
    int mCnt   = 0;

    logic [3:0] drCode [9] = '{4'hF, 4'hC, 4'h7, 4'h6, 4'h2, 4'h1, 4'h3, 4'h0, 4'h5};
    logic [3:0] irCode [9] = '{4'hF, 4'hC, 4'h4, 4'hE, 4'hA, 4'h9, 4'hB, 4'h8, 4'hD};

    logic [8:0] dutCtrl;
    assign dutCtrl = {Test_Log_Res, Shift_IR, IR_Sh_t_en, IR_Com_t_en,
                      Shift_DR, DR_Sh_t_en, DR_Com_t_en, Sel_IR, TDO_en};

    tap_controller #(.RTI_CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .TMS          (TMS),
        .Test_Log_Res (Test_Log_Res),
        .Shift_IR     (Shift_IR),
        .IR_Sh_t_en   (IR_Sh_t_en),
        .IR_Com_t_en  (IR_Com_t_en),
        .Shift_DR     (Shift_DR),
        .DR_Sh_t_en   (DR_Sh_t_en),
        .DR_Com_t_en  (DR_Com_t_en),
        .Sel_IR       (Sel_IR),
        .TDO_en       (TDO_en),
        .Tap_state    (Tap_state)
`ifdef TAP_RTI_CNT_EN
        ,
        .Rti_cnt      (Rti_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state code and controls derived from (phase, branch).
    function automatic logic [3:0] modelCode();
        return mIr ? irCode[mPhase] : drCode[mPhase];
    endfunction

    function automatic logic [8:0] modelCtrl();
        bit tlr, sh, shEn, up;
        tlr  = (mPhase == P_TLR);
        sh   = (mPhase == P_SH);
        shEn = (mPhase == P_CAP) || sh;
        up   = (mPhase == P_UP);
        return {tlr, sh & mIr, shEn & mIr, up & mIr,
                sh & !mIr, shEn & !mIr, up & !mIr, mIr | tlr, sh};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model advances on the same edges as the DUT.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mPhase = P_TLR;
            mIr    = 0;
            mCnt   = 0;
        end else begin
            int oldPhase;
            oldPhase = mPhase;
            case (mPhase)
                P_TLR: if (!TMS) mPhase = P_RTI;
                P_RTI: if (TMS) mPhase = P_SEL;
                P_SEL: begin
                    if (!TMS)     mPhase = P_CAP;
                    else if (!mIr) mIr = 1;
                    else begin mPhase = P_TLR; mIr = 0; end
                end
                P_CAP, P_SH: mPhase = TMS ? P_EX1 : P_SH;
                P_EX1:       mPhase = TMS ? P_UP  : P_PS;
                P_PS:        mPhase = TMS ? P_EX2 : P_PS;
                P_EX2:       mPhase = TMS ? P_UP  : P_SH;
                P_UP: begin mPhase = TMS ? P_SEL : P_RTI; mIr = 0; end
                default: mPhase = P_TLR;
            endcase
            if (mPhase == P_CAP)          mCnt = 0;
            else if (oldPhase == P_RTI && mCnt < CNT_MAX) mCnt = mCnt + 1;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("state", {28'd0, Tap_state}, {28'd0, modelCode()});
            checkOutput("ctrl", {23'd0, dutCtrl}, {23'd0, modelCtrl()});
`ifdef TAP_RTI_CNT_EN
            checkOutput("rti_cnt", {28'd0, Rti_cnt}, mCnt);
`endif
        end
    end

    task automatic applyStimulus(input bit tms);
        TMS = tms;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] seq1Code [5];
        bit         seq1Tms  [5];
        bit         seq1Sh   [5];
        bit         seq1En   [5];
        bit         scanTms  [10];
        bit         pauseTms [8];
        bit         pauseDrSh[8];
        bit         pauseTdo [8];
        int         comPulses;
        int         comIdx;
        int         drSeen;
        int         onesRun;

        seq1Tms   = '{0, 1, 1, 0, 0};
        seq1Code  = '{4'hC, 4'h7, 4'h4, 4'hE, 4'hA};
        seq1Sh    = '{0, 0, 0, 0, 1};
        seq1En    = '{0, 0, 0, 1, 1};
        scanTms   = '{0, 1, 1, 0, 0, 0, 0, 1, 1, 0};
        pauseTms  = '{1, 0, 1, 0, 0, 0, 1, 0};
        pauseDrSh = '{0, 1, 0, 0, 0, 0, 0, 1};
        pauseTdo  = '{0, 0, 0, 0, 0, 0, 0, 1};

        reset   = 1'b0;
        TMS     = 1'b0;
        checkEn = 1;
        #12;
        checkOutput("reset_state", {28'd0, Tap_state}, 32'hF);
        checkOutput("reset_ctrl", {23'd0, dutCtrl}, 32'h102);
        reset = 1'b1;

        // TLR -> RTI -> SELDR -> SELIR -> CAPIR -> SHIR
        for (int i = 0; i < 5; i++) begin
            applyStimulus(seq1Tms[i]);
            checkOutput("seq1_state", {28'd0, Tap_state}, {28'd0, seq1Code[i]});
            checkOutput("seq1_shift_ir", {31'd0, Shift_IR}, {31'd0, seq1Sh[i]});
            checkOutput("seq1_ir_sh_en", {31'd0, IR_Sh_t_en}, {31'd0, seq1En[i]});
        end

        // SHIR -> EX1IR -> UPIR -> SELDR -> CAPDR -> SHDR, then five ones
        applyStimulus(1); applyStimulus(1); applyStimulus(1);
        applyStimulus(0); applyStimulus(0);
        checkOutput("at_shdr", {28'd0, Tap_state}, 32'h2);
        for (int i = 0; i < 5; i++) applyStimulus(1);
        checkOutput("five_ones_state", {28'd0, Tap_state}, 32'hF);
        checkOutput("five_ones_tlr", {31'd0, Test_Log_Res}, 32'd1);

        // Full IR scan from TLR; single Update-IR pulse, DR side untouched
        comPulses = 0; comIdx = -1; drSeen = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(scanTms[i]);
            if (IR_Com_t_en) begin comPulses++; comIdx = i; end
            if (Shift_DR | DR_Sh_t_en | DR_Com_t_en) drSeen++;
        end
        checkOutput("ir_com_pulses", comPulses, 32'd1);
        checkOutput("ir_com_index", comIdx, 32'd8);
        checkOutput("ir_scan_dr_quiet", drSeen, 32'd0);
        checkOutput("ir_scan_end", {28'd0, Tap_state}, 32'hC);

        // RTI -> SELDR -> CAPDR -> EX1DR -> PSDR x3 -> EX2DR -> SHDR
        for (int i = 0; i < 8; i++) begin
            applyStimulus(pauseTms[i]);
            checkOutput("pause_dr_sh", {31'd0, DR_Sh_t_en}, {31'd0, pauseDrSh[i]});
            checkOutput("pause_tdo_en", {31'd0, TDO_en}, {31'd0, pauseTdo[i]});
            checkOutput("pause_sel_ir", {31'd0, Sel_IR}, 32'd0);
        end
        checkOutput("pause_end", {28'd0, Tap_state}, 32'h2);

        // SHDR -> EX1DR -> UPDR -> SELDR -> SELIR -> CAPIR -> SHIR, then async reset
        applyStimulus(1); applyStimulus(1); applyStimulus(1);
        applyStimulus(1); applyStimulus(0); applyStimulus(0);
        checkOutput("at_shir", {28'd0, Tap_state}, 32'hA);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async_reset_state", {28'd0, Tap_state}, 32'hF);
        checkOutput("async_reset_ctrl", {23'd0, dutCtrl}, 32'h102);
        @(negedge clk);
        #1;
        reset = 1'b1;

`ifdef TAP_RTI_CNT_EN
        // Hold RTI for 20 edges, leave via SELDR, clear on CAPDR
        applyStimulus(0);
        for (int i = 0; i < 20; i++) applyStimulus(0);
        checkOutput("rti_cnt_sat", {28'd0, Rti_cnt}, 32'd15);
        applyStimulus(1);
        applyStimulus(0);
        checkOutput("rti_cnt_capdr", {28'd0, Rti_cnt}, 32'd0);
`endif

        // Random walk with occasional asynchronous reset pulses
        onesRun = 0;
        for (int i = 0; i < 600; i++) begin
            bit t;
            t = 1'($urandom_range(0, 1));
            applyStimulus(t);
            onesRun = t ? onesRun + 1 : 0;
            if (onesRun >= 5)
                checkOutput("rand_five_ones", {28'd0, Tap_state}, 32'hF);
            if ($urandom_range(0, 59) == 0) begin
                reset = 1'b0;
                #1;
                checkOutput("rand_async_reset", {28'd0, Tap_state}, 32'hF);
                reset = 1'b1;
                onesRun = 0;
            end
        end

        @(negedge clk);
        checkEn = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
